// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, signed/unsigned, one quotient bit per clock
module seq_divider #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_signed,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         OF
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]    rem_q, rem_d;     // partial remainder, one extra bit for the trial sign
   logic [N-1:0]  wq_q, wq_d;       // starts as |dividend|, shifts out as quotient shifts in
   logic [N-1:0]  dsr_q, dsr_d;     // |divisor|
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic          ovf_q, ovf_d;     // MIN / -1 seen at issue
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rmd_q, rmd_d;
   logic          dbz_q, dbz_d;
   logic          of_q, of_d;

   logic          dvd_neg, dsr_neg;
   logic [N-1:0]  dvd_mag, dsr_mag;
   logic [N:0]    r_shift, trial;
   logic [N-1:0]  min_val;

   assign min_val = {1'b1, {(N-1){1'b0}}};
   assign dvd_neg = is_signed & dividend[N-1];
   assign dsr_neg = is_signed & divisor[N-1];
   // |MIN| wraps back to the bit pattern 2^(N-1), which is exactly the unsigned magnitude
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dsr_mag = dsr_neg ? -divisor : divisor;
   assign r_shift = {rem_q[N-1:0], wq_q[N-1]};
   assign trial   = r_shift - {1'b0, dsr_q};

   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;
   assign OF          = of_q;

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         wq_q    <= '0;
         dsr_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         ovf_q   <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
         of_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         wq_q    <= wq_d;
         dsr_q   <= dsr_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         ovf_q   <= ovf_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
         of_q    <= of_d;
      end
   end

   // Next-state, iteration and result-load logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      wq_d    = wq_q;
      dsr_d   = dsr_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      ovf_d   = ovf_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      of_d    = of_q;
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               dbz_d  = 1'b0;
               of_d   = 1'b0;
               qneg_d = dvd_neg ^ dsr_neg;
               rneg_d = dvd_neg;
               ovf_d  = is_signed && (dividend == min_val) && (divisor == '1);
               rem_d  = '0;
               wq_d   = dvd_mag;
               dsr_d  = dsr_mag;
               cnt_d  = CW'(N);
               if (divisor == '0) begin
                  quo_d   = '1;
                  rmd_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            if (!trial[N]) begin
               rem_d = trial;
               wq_d  = {wq_q[N-2:0], 1'b1};
            end else begin
               rem_d = r_shift;
               wq_d  = {wq_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // Sign flags are only ever set in signed mode, so unsigned passes straight through
            quo_d   = qneg_q ? -wq_q : wq_q;
            rmd_d   = rneg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
            of_d    = ovf_q;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider at N=8 and N=32
module tb_seq_divider;

   logic        clk;
   logic        rst_n;

   logic        start8, sgn8, busy8, done8, dz8, of8;
   logic [7:0]  a8, b8, q8, r8;
   logic        start32, sgn32, busy32, done32, dz32, of32;
   logic [31:0] a32, b32, q32, r32;

   int errors = 0;
   int checks = 0;
   int dcnt8  = 0;
   int dcnt32 = 0;

   seq_divider #(.N(8)) u_div8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
      .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .div_by_zero(dz8), .OF(of8)
   );

   seq_divider #(.N(32)) u_div32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sgn32),
      .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
      .quotient(q32), .remainder(r32), .div_by_zero(dz32), .OF(of32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done8 === 1'b1) dcnt8 <= dcnt8 + 1;
      if (done32 === 1'b1) dcnt32 <= dcnt32 + 1;
   end

   typedef struct {
      bit          w;
      bit          s;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] q;
      logic [63:0] r;
      bit          dz;
      bit          of;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] cur_q(input bit w);
      return w ? 64'(q32) : 64'(q8);
   endfunction
   function automatic logic [63:0] cur_r(input bit w);
      return w ? 64'(r32) : 64'(r8);
   endfunction
   function automatic logic cur_done(input bit w);
      return w ? done32 : done8;
   endfunction
   function automatic logic cur_busy(input bit w);
      return w ? busy32 : busy8;
   endfunction

   // Reference: plain integer division with C truncation semantics
   function automatic void model(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] q, output logic [63:0] r,
                                 output logic dz, output logic of);
      int          n;
      logic [63:0] mask, am, bm;
      longint      sa, sb;
      n    = w ? 32 : 8;
      mask = (64'd1 << n) - 64'd1;
      am   = a & mask;
      bm   = b & mask;
      dz   = 1'b0;
      of   = 1'b0;
      if (bm == 64'd0) begin
         q  = mask;
         r  = am;
         dz = 1'b1;
      end else if (s) begin
         sa = am[n-1] ? longint'(am | ~mask) : longint'(am);
         sb = bm[n-1] ? longint'(bm | ~mask) : longint'(bm);
         of = (am == (64'd1 << (n - 1))) && (bm == mask);
         q  = 64'(sa / sb) & mask;
         r  = 64'(sa % sb) & mask;
      end else begin
         q = am / bm;
         r = am % bm;
      end
   endfunction

   task automatic do_op(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] q, output logic [63:0] r,
                        output logic dz, output logic of, output int lat);
      logic [63:0] pq, pr;
      logic        held;
      @(negedge clk);
      pq = cur_q(w);
      pr = cur_r(w);
      if (w) begin
         start32 = 1'b1; sgn32 = s; a32 = a[31:0]; b32 = b[31:0];
      end else begin
         start8 = 1'b1; sgn8 = s; a8 = a[7:0]; b8 = b[7:0];
      end
      @(posedge clk);
      #1;
      start8  = 1'b0;
      start32 = 1'b0;
      a8  = 8'($urandom);  b8  = 8'($urandom);  sgn8  = ~sgn8;
      a32 = $urandom;      b32 = $urandom;      sgn32 = ~sgn32;
      lat  = 1;
      held = 1'b1;
      while (!cur_done(w) && lat < 200) begin
         if (cur_q(w) !== pq || cur_r(w) !== pr) held = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("done_seen", 64'(cur_done(w)), 64'd1);
      chk("hold_during_div", 64'(held), 64'd1);
      q  = cur_q(w);
      r  = cur_r(w);
      dz = w ? dz32 : dz8;
      of = w ? of32 : of8;
      @(posedge clk);
      #1;
      chk("done_one_cycle", 64'(cur_done(w)), 64'd0);
      chk("idle_after_done", 64'(cur_busy(w)), 64'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy8"}, 64'(busy8), 64'd0);
      chk({tag, "_done8"}, 64'(done8), 64'd0);
      chk({tag, "_q8"}, 64'(q8), 64'd0);
      chk({tag, "_r8"}, 64'(r8), 64'd0);
      chk({tag, "_dz8"}, 64'(dz8), 64'd0);
      chk({tag, "_of8"}, 64'(of8), 64'd0);
      chk({tag, "_busy32"}, 64'(busy32), 64'd0);
      chk({tag, "_q32"}, 64'(q32), 64'd0);
      chk({tag, "_r32"}, 64'(r32), 64'd0);
      chk({tag, "_of32"}, 64'(of32), 64'd0);
   endtask

   initial begin
      vec_t        tbl [14];
      logic [63:0] q, r, eq, er, a, b;
      logic        dz, of, edz, eof;
      int          lat, d0, rsel;
      bit          s;

      rst_n = 1'b1;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
      #2 rst_n = 1'b0;
      #1 chk_reset("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      //            w  s   a               b               q               r               dz of lat
      tbl[0]  = '{0, 0, 64'd200,        64'd7,          64'd28,         64'd4,          0, 0, 10};
      tbl[1]  = '{0, 1, 64'hF9,         64'h02,         64'hFD,         64'hFF,         0, 0, 10};
      tbl[2]  = '{0, 1, 64'h07,         64'hFE,         64'hFD,         64'h01,         0, 0, 10};
      tbl[3]  = '{0, 0, 64'd13,         64'd0,          64'hFF,         64'd13,         1, 0, 1};
      tbl[4]  = '{0, 1, 64'd13,         64'd0,          64'hFF,         64'd13,         1, 0, 1};
      tbl[5]  = '{0, 1, 64'h80,         64'hFF,         64'h80,         64'h00,         0, 1, 10};
      tbl[6]  = '{0, 0, 64'h80,         64'hFF,         64'h00,         64'h80,         0, 0, 10};
      tbl[7]  = '{0, 1, 64'h80,         64'h01,         64'h80,         64'h00,         0, 0, 10};
      tbl[8]  = '{0, 1, 64'hF9,         64'hF9,         64'h01,         64'h00,         0, 0, 10};
      tbl[9]  = '{0, 0, 64'd5,          64'd9,          64'd0,          64'd5,          0, 0, 10};
      tbl[10] = '{0, 1, 64'hF3,         64'h00,         64'hFF,         64'hF3,         1, 0, 1};
      tbl[11] = '{1, 0, 64'hFFFFFFFF,   64'd1,          64'hFFFFFFFF,   64'd0,          0, 0, 34};
      tbl[12] = '{1, 1, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFD,   64'hFFFFFFFF,   0, 0, 34};
      tbl[13] = '{1, 1, 64'h80000000,   64'hFFFFFFFF,   64'h80000000,   64'd0,          0, 1, 34};

      for (int i = 0; i < 14; i++) begin
         do_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, q, r, dz, of, lat);
         chk($sformatf("vec%0d_q", i), q, tbl[i].q);
         chk($sformatf("vec%0d_r", i), r, tbl[i].r);
         chk($sformatf("vec%0d_dz", i), 64'(dz), 64'(tbl[i].dz));
         chk($sformatf("vec%0d_of", i), 64'(of), 64'(tbl[i].of));
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      end

      // start held through a whole operation, operands changed mid-DIV
      @(negedge clk);
      start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
      d0 = dcnt8;
      @(posedge clk);
      #1;
      lat = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         lat++;
      end
      a8 = 8'd9; b8 = 8'd3; sgn8 = 1'b1;
      chk("held_busy_mid", 64'(busy8), 64'd1);
      while (!done8 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("held_lat", 64'(lat), 64'd10);
      chk("held_q", 64'(q8), 64'd28);
      chk("held_r", 64'(r8), 64'd4);
      @(posedge clk);
      #1;
      start8 = 1'b0;
      chk("held_start_ignored_in_done", 64'(busy8), 64'd0);
      chk("held_one_result", 64'(dcnt8 - d0), 64'd1);

      // reset asserted in the middle of DIV
      @(negedge clk);
      start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd100; b8 = 8'd3;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      chk("abort_busy_before", 64'(busy8), 64'd1);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset("abort");
      @(negedge clk) rst_n = 1'b1;
      do_op(1'b0, 1'b0, 64'd100, 64'd3, q, r, dz, of, lat);
      chk("after_abort_q", q, 64'd33);
      chk("after_abort_r", r, 64'd1);
      chk("after_abort_lat", 64'(lat), 64'd10);

      // random back-to-back operations against the reference model
      for (int w = 0; w < 2; w++) begin
         d0 = (w == 1) ? dcnt32 : dcnt8;
         for (int i = 0; i < 1000; i++) begin
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            s    = 1'($urandom);
            rsel = int'($urandom_range(0, 19));
            if (rsel == 0) b = 64'd0;
            if (rsel == 1) begin
               s = 1'b1;
               a = (w == 1) ? 64'h80000000 : 64'h80;
               b = 64'hFFFFFFFFFFFFFFFF;
            end
            if (rsel == 2) b = 64'd1;
            model(w[0], s, a, b, eq, er, edz, eof);
            do_op(w[0], s, a, b, q, r, dz, of, lat);
            chk($sformatf("rnd_w%0d_%0d_q", w, i), q, eq);
            chk($sformatf("rnd_w%0d_%0d_r", w, i), r, er);
            chk($sformatf("rnd_w%0d_%0d_dz", w, i), 64'(dz), 64'(edz));
            chk($sformatf("rnd_w%0d_%0d_of", w, i), 64'(of), 64'(eof));
            chk($sformatf("rnd_w%0d_%0d_lat", w, i), 64'(lat),
                edz ? 64'd1 : ((w == 1) ? 64'd34 : 64'd10));
         end
         chk($sformatf("rnd_w%0d_done_count", w),
             64'(((w == 1) ? dcnt32 : dcnt8) - d0), 64'd1000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's multipliers and the subtract-direction counterpart of the ripple adder.
- Computes quotient and remainder of two N-bit operands, one quotient bit per clock.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Sits beside the multiplier blocks as the datapath's divide unit, with a start/done handshake.

Parameters:
- N, 32, operand and result width in bits; legal range 4..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands; sampled with start.
- dividend  input  N  numerator; sampled with start.
- divisor  input  N  denominator; sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  N  registered quotient.
- remainder  output  N  registered remainder.
- div_by_zero  output  1  divisor was 0 for the last operation.
- OF  output  1  signed overflow (MIN / -1) on the last operation.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, quotient, remainder, div_by_zero and OF all 0.
- Reset mid-operation aborts immediately; no partial result is ever presented.
- States: IDLE, DIV, FIX, DONE.
- IDLE, start=1: latch sign flags, operand magnitudes, is_signed; clear both flags.
  - Magnitudes are taken only when is_signed=1 and the operand MSB is 1; otherwise operands are used raw.
  - |MIN| is held as unsigned 2^(N-1); no widening is needed.
  - divisor==0: go to DONE directly; quotient = all ones, remainder = dividend (raw), div_by_zero=1.
  - Otherwise: go to DIV with counter = N.
- DIV, one iteration per cycle:
  - Partial remainder R is N+1 bits.
  - R' = {R[N-1:0], Q[N-1]}, then Q shifts left by one.
  - Trial = R' - {0, |divisor|}.
  - Trial >= 0: R = trial, Q[0] = 1. Otherwise R = R', Q[0] = 0.
  - Counter decrements; after the Nth iteration go to FIX.
- FIX (signed mode only; unsigned passes through):
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative; remainder sign follows dividend, C-style truncation.
  - Signed dividend = MIN with divisor = -1: quotient = MIN (natural wrap), remainder = 0, OF=1.
  - Load quotient/remainder, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency, counted from the clock edge that samples start:
  - Normal operation: done high N+2 cycles later.
  - Divide-by-zero: done high 1 cycle later.
- quotient, remainder and the flags hold their values until the next result loads. They do not change during DIV.
- start while busy (including the DONE cycle) is ignored; no queuing.
- Operand changes after the sampling edge have no effect.
- Back-to-back: start asserted in the cycle after DONE is accepted. Minimum issue interval is N+3 cycles.

Test Plan:
- N=8 unsigned, 200/7 -> quotient=28, remainder=4, flags 0; done exactly 10 cycles after start is sampled; busy high for 10 cycles.
- N=8 signed, -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1). Signed 7/-2 -> quotient=0xFD, remainder=0x01.
- N=8, 13/0 in both modes -> quotient=0xFF, remainder=13, div_by_zero=1, done 1 cycle after start.
- N=8 signed, 0x80/0xFF -> quotient=0x80, remainder=0, OF=1. Same operands unsigned -> quotient=0, remainder=0x80, OF=0.
- Hold start high through a whole operation, toggle operands mid-DIV, then pull rst_n low during DIV:
  - Exactly one result computed from the sampled operands.
  - Reset clears all outputs asynchronously, before the next edge.
  - The next operation returns correct results.
- 2000 random operand pairs, N=8 and N=32, random is_signed, back-to-back starts -> every result matches a behavioral model; done count equals accepted starts.
